// File: rtl/reg_writeback_pkg.sv
// Shared register-file types and write-back defaults.
// Holds bus widths, typedefs and the load-queue depth.
package reg_writeback_pkg;

   localparam int RegAddrW = 5;
   localparam int RegDataW = 32;
   localparam int LdQDepth = 4;

   typedef logic [RegAddrW-1:0] RegAddrBus;
   typedef logic [RegDataW-1:0] RegBus;
   typedef logic                WriteEnable;

endpackage

// File: rtl/reg_writeback_if.sv
// Write-back bus: pipeline write, load handshake, rf port, pend query.
// master drives requests/queries, slave (reg_writeback) drives results.
interface reg_writeback_if
   import reg_writeback_pkg::*;
#(
   parameter int ADDR_W = RegAddrW,
   parameter int DATA_W = RegDataW
);

   logic              pipe_we;
   logic [ADDR_W-1:0] pipe_waddr;
   logic [DATA_W-1:0] pipe_wdata;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_waddr;
   logic [DATA_W-1:0] ld_wdata;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [ADDR_W-1:0] q_raddr1;
   logic [ADDR_W-1:0] q_raddr2;
   logic              pend1;
   logic              pend2;

   modport master (
      output pipe_we, pipe_waddr, pipe_wdata,
      output ld_valid, ld_waddr, ld_wdata,
      output q_raddr1, q_raddr2,
      input  ld_ready, rf_we, rf_waddr, rf_wdata,
      input  pend1, pend2
   );

   modport slave (
      input  pipe_we, pipe_waddr, pipe_wdata,
      input  ld_valid, ld_waddr, ld_wdata,
      input  q_raddr1, q_raddr2,
      output ld_ready, rf_we, rf_waddr, rf_wdata,
      output pend1, pend2
   );

endinterface

// File: rtl/wb_ldq.sv
// Load-completion FIFO with per-entry live bit, kill-by-address and
// pend lookup. Ports: push/pop, kill, head view, ready/empty, pend1/2.
module wb_ldq #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              kill,
   input  logic [ADDR_W-1:0] kill_addr,
   input  logic [ADDR_W-1:0] q_raddr1,
   input  logic [ADDR_W-1:0] q_raddr2,
   output logic              ready,
   output logic              empty,
   output logic              head_live,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              pend1,
   output logic              pend2
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [CW-1:0]     count;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [DEPTH-1:0]  live;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   // ready comes only from the registered count
   assign ready     = !rst && (count < CW'(DEPTH));
   assign empty     = (count == '0);
   assign head_live = live[rd_ptr];
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         live   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill && addr_q[i] == kill_addr)
               live[i] <= 1'b0;
         end
         if (push) begin
            live[wr_ptr]   <= 1'b1;
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) begin
            live[rd_ptr] <= 1'b0;
            rd_ptr       <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i] && addr_q[i] == q_raddr1) pend1 = 1'b1;
         if (live[i] && addr_q[i] == q_raddr2) pend2 = 1'b1;
      end
      if (rst || q_raddr1 == '0) pend1 = 1'b0;
      if (rst || q_raddr2 == '0) pend2 = 1'b0;
   end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: pipeline writes win, queued loads
// drain into idle slots. Ports: clk, rst, bus (reg_writeback_if.slave).
module reg_writeback
   import reg_writeback_pkg::*;
#(
   parameter int DEPTH  = LdQDepth,
   parameter int ADDR_W = RegAddrW,
   parameter int DATA_W = RegDataW
) (
   input  logic           clk,
   input  logic           rst,
   reg_writeback_if.slave bus
);

   logic              pipe_ok;
   logic              ld_xfer;
   logic              ld_ok;
   logic              q_ready;
   logic              q_empty;
   logic              q_push;
   logic              q_pop;
   logic              head_live;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign pipe_ok = bus.pipe_we && (bus.pipe_waddr != '0);
   assign ld_xfer = bus.ld_valid && q_ready;
   // x0 loads and loads overtaken by a same-cycle pipe write vanish
   assign ld_ok   = ld_xfer && (bus.ld_waddr != '0) &&
                    !(pipe_ok && bus.pipe_waddr == bus.ld_waddr);
   assign q_pop   = !pipe_ok && !q_empty;
   // a load bypasses the queue only when nothing else wants the slot
   assign q_push  = ld_ok && (pipe_ok || !q_empty);

   assign bus.ld_ready = q_ready;

   wb_ldq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ldq (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_addr (bus.ld_waddr),
      .push_data (bus.ld_wdata),
      .pop       (q_pop),
      .kill      (pipe_ok),
      .kill_addr (bus.pipe_waddr),
      .q_raddr1  (bus.q_raddr1),
      .q_raddr2  (bus.q_raddr2),
      .ready     (q_ready),
      .empty     (q_empty),
      .head_live (head_live),
      .head_addr (head_addr),
      .head_data (head_data),
      .pend1     (bus.pend1),
      .pend2     (bus.pend2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rf_we    <= 1'b0;
         bus.rf_waddr <= '0;
         bus.rf_wdata <= '0;
      end else if (pipe_ok) begin
         bus.rf_we    <= 1'b1;
         bus.rf_waddr <= bus.pipe_waddr;
         bus.rf_wdata <= bus.pipe_wdata;
      end else if (!q_empty) begin
         // a killed head still burns this slot
         bus.rf_we    <= head_live;
         bus.rf_waddr <= head_addr;
         bus.rf_wdata <= head_data;
      end else if (ld_ok) begin
         bus.rf_we    <= 1'b1;
         bus.rf_waddr <= bus.ld_waddr;
         bus.rf_wdata <= bus.ld_wdata;
      end else begin
         bus.rf_we    <= 1'b0;
      end
   end

endmodule
